// File: rtl/idex_register_pkg.sv
// Shared core definitions for decode and execute: NOP encoding, CSR operation codes,
// and the ID/EX pipeline payload with its bubble value.
package idex_register_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    CSR_NONE = 3'b000,
    CSR_RW   = 3'b001,
    CSR_RS   = 3'b010,
    CSR_RC   = 3'b011,
    CSR_RWI  = 3'b101,
    CSR_RSI  = 3'b110,
    CSR_RCI  = 3'b111
  } csr_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] porta;
    logic [31:0] portb;
    logic [31:0] imm;
    logic [4:0]  waddr;
    logic        we;
    logic        mem_flags;
    logic        mem_ex_sel;
    logic        jump_op;
    logic        branch_op;
    logic        break_op;
    logic        syscall_op;
    logic        csr_imm_op;
    logic        bad_jump_addr;
    logic        bad_branch_addr;
    logic [2:0]  csr_op;
    logic        valid;
  } idex_t;

  // A bubble is all-zero except for the NOP instruction word, so it retires harmlessly.
  function automatic idex_t make_bubble();
    idex_t b;
    b             = '0;
    b.instruction = NOP;
    b.csr_op      = CSR_NONE;
    return b;
  endfunction

  localparam idex_t IDEX_BUBBLE = make_bubble();

endpackage

// File: rtl/idex_register_pipe_reg.sv
// Generic pipeline stage register with hold and clear; clear wins over hold so a
// flushed stage never keeps a stalled instruction.
module pipe_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q <= CLEAR_VALUE;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/idex_register.sv
// ID/EX pipeline register: one-cycle registered copy of decode outputs with
// flush, stall and bubble insertion.
module idex_register
  import idex_register_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_instruction,
  input  logic [31:0] id_porta,
  input  logic [31:0] id_portb,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_waddr,
  input  logic        id_we,
  input  logic        id_mem_flags,
  input  logic        id_mem_ex_sel,
  input  logic        id_jump_op,
  input  logic        id_branch_op,
  input  logic        id_break_op,
  input  logic        id_syscall_op,
  input  logic        id_csr_imm_op,
  input  logic        id_bad_jump_addr,
  input  logic        id_bad_branch_addr,
  input  logic [2:0]  id_csr_op,
  input  logic        id_stall,
  input  logic        id_flush,
  input  logic        ex_stall,
  input  logic        ex_flush,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_instruction,
  output logic [31:0] ex_porta,
  output logic [31:0] ex_portb,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_waddr,
  output logic        ex_we,
  output logic        ex_mem_flags,
  output logic        ex_mem_ex_sel,
  output logic        ex_jump_op,
  output logic        ex_branch_op,
  output logic        ex_break_op,
  output logic        ex_syscall_op,
  output logic        ex_csr_imm_op,
  output logic        ex_bad_jump_addr,
  output logic        ex_bad_branch_addr,
  output logic [2:0]  ex_csr_op,
  output logic        ex_valid
);

  idex_t next_value;
  idex_t stage_q;

  // A stalled or killed decode instruction enters execute as a bubble; ex_stall/ex_flush
  // are resolved inside pipe_reg so they take priority over this selection.
  always_comb begin
    next_value = IDEX_BUBBLE;
    if (!(id_stall || id_flush)) begin
      next_value.pc              = id_pc;
      next_value.instruction     = id_instruction;
      next_value.porta           = id_porta;
      next_value.portb           = id_portb;
      next_value.imm             = id_imm;
      next_value.waddr           = id_waddr;
      next_value.we              = id_we;
      next_value.mem_flags       = id_mem_flags;
      next_value.mem_ex_sel      = id_mem_ex_sel;
      next_value.jump_op         = id_jump_op;
      next_value.branch_op       = id_branch_op;
      next_value.break_op        = id_break_op;
      next_value.syscall_op      = id_syscall_op;
      next_value.csr_imm_op      = id_csr_imm_op;
      next_value.bad_jump_addr   = id_bad_jump_addr;
      next_value.bad_branch_addr = id_bad_branch_addr;
      next_value.csr_op          = id_csr_op;
      next_value.valid           = 1'b1;
    end
  end

  pipe_reg #(
    .WIDTH      ($bits(idex_t)),
    .CLEAR_VALUE(IDEX_BUBBLE)
  ) u_stage (
    .clk  (clk),
    .rst  (rst),
    .hold (ex_stall),
    .clear(ex_flush),
    .d    (next_value),
    .q    (stage_q)
  );

  assign ex_pc              = stage_q.pc;
  assign ex_instruction     = stage_q.instruction;
  assign ex_porta           = stage_q.porta;
  assign ex_portb           = stage_q.portb;
  assign ex_imm             = stage_q.imm;
  assign ex_waddr           = stage_q.waddr;
  assign ex_we              = stage_q.we;
  assign ex_mem_flags       = stage_q.mem_flags;
  assign ex_mem_ex_sel      = stage_q.mem_ex_sel;
  assign ex_jump_op         = stage_q.jump_op;
  assign ex_branch_op       = stage_q.branch_op;
  assign ex_break_op        = stage_q.break_op;
  assign ex_syscall_op      = stage_q.syscall_op;
  assign ex_csr_imm_op      = stage_q.csr_imm_op;
  assign ex_bad_jump_addr   = stage_q.bad_jump_addr;
  assign ex_bad_branch_addr = stage_q.bad_branch_addr;
  assign ex_csr_op          = stage_q.csr_op;
  assign ex_valid           = stage_q.valid;

endmodule

// File: tb/tb_idex_register.sv
// Directed bench for idex_register: a reference model pushes expected register
// contents to a scoreboard queue each cycle; the entry is popped and compared after the edge.
module tb_idex_register;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] porta;
    logic [31:0] portb;
    logic [31:0] imm;
    logic [4:0]  waddr;
    logic [9:0]  ctrl;
    logic [2:0]  csr;
    logic        valid;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_pc, id_instruction, id_porta, id_portb, id_imm;
  logic [4:0]  id_waddr;
  logic        id_we, id_mem_flags, id_mem_ex_sel, id_jump_op, id_branch_op;
  logic        id_break_op, id_syscall_op, id_csr_imm_op;
  logic        id_bad_jump_addr, id_bad_branch_addr;
  logic [2:0]  id_csr_op;
  logic        id_stall, id_flush, ex_stall, ex_flush;

  logic [31:0] ex_pc, ex_instruction, ex_porta, ex_portb, ex_imm;
  logic [4:0]  ex_waddr;
  logic        ex_we, ex_mem_flags, ex_mem_ex_sel, ex_jump_op, ex_branch_op;
  logic        ex_break_op, ex_syscall_op, ex_csr_imm_op;
  logic        ex_bad_jump_addr, ex_bad_branch_addr;
  logic [2:0]  ex_csr_op;
  logic        ex_valid;

  exp_t model;
  exp_t scoreboard[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  idex_register dut (
    .clk(clk), .rst(rst),
    .id_pc(id_pc), .id_instruction(id_instruction), .id_porta(id_porta),
    .id_portb(id_portb), .id_imm(id_imm), .id_waddr(id_waddr), .id_we(id_we),
    .id_mem_flags(id_mem_flags), .id_mem_ex_sel(id_mem_ex_sel),
    .id_jump_op(id_jump_op), .id_branch_op(id_branch_op), .id_break_op(id_break_op),
    .id_syscall_op(id_syscall_op), .id_csr_imm_op(id_csr_imm_op),
    .id_bad_jump_addr(id_bad_jump_addr), .id_bad_branch_addr(id_bad_branch_addr),
    .id_csr_op(id_csr_op), .id_stall(id_stall), .id_flush(id_flush),
    .ex_stall(ex_stall), .ex_flush(ex_flush),
    .ex_pc(ex_pc), .ex_instruction(ex_instruction), .ex_porta(ex_porta),
    .ex_portb(ex_portb), .ex_imm(ex_imm), .ex_waddr(ex_waddr), .ex_we(ex_we),
    .ex_mem_flags(ex_mem_flags), .ex_mem_ex_sel(ex_mem_ex_sel),
    .ex_jump_op(ex_jump_op), .ex_branch_op(ex_branch_op), .ex_break_op(ex_break_op),
    .ex_syscall_op(ex_syscall_op), .ex_csr_imm_op(ex_csr_imm_op),
    .ex_bad_jump_addr(ex_bad_jump_addr), .ex_bad_branch_addr(ex_bad_branch_addr),
    .ex_csr_op(ex_csr_op), .ex_valid(ex_valid)
  );

  function automatic exp_t bubble_value();
    exp_t b;
    b.pc = '0; b.instr = NOP_WORD; b.porta = '0; b.portb = '0; b.imm = '0;
    b.waddr = '0; b.ctrl = '0; b.csr = 3'b000; b.valid = 1'b0;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (scoreboard.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s scoreboard empty observed=0 expected=1", tag);
      return;
    end
    e = scoreboard.pop_front();
    chk({tag, ".pc"},    ex_pc, e.pc);
    chk({tag, ".instr"}, ex_instruction, e.instr);
    chk({tag, ".porta"}, ex_porta, e.porta);
    chk({tag, ".portb"}, ex_portb, e.portb);
    chk({tag, ".imm"},   ex_imm, e.imm);
    chk({tag, ".waddr"}, {27'd0, ex_waddr}, {27'd0, e.waddr});
    chk({tag, ".ctrl"},  {22'd0, ex_we, ex_mem_flags, ex_mem_ex_sel, ex_jump_op, ex_branch_op,
                          ex_break_op, ex_syscall_op, ex_csr_imm_op, ex_bad_jump_addr,
                          ex_bad_branch_addr}, {22'd0, e.ctrl});
    chk({tag, ".csr"},   {29'd0, ex_csr_op}, {29'd0, e.csr});
    chk({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, e.valid});
  endtask

  // Reference model of one edge, applied in priority order, then the edge itself and a check.
  task automatic applyStimulus(input string tag);
    exp_t nxt;
    if (rst || ex_flush) begin
      nxt = bubble_value();
    end else if (ex_stall) begin
      nxt = model;
    end else if (id_stall || id_flush) begin
      nxt = bubble_value();
    end else begin
      nxt.pc = id_pc; nxt.instr = id_instruction; nxt.porta = id_porta;
      nxt.portb = id_portb; nxt.imm = id_imm; nxt.waddr = id_waddr;
      nxt.ctrl = {id_we, id_mem_flags, id_mem_ex_sel, id_jump_op, id_branch_op,
                  id_break_op, id_syscall_op, id_csr_imm_op, id_bad_jump_addr,
                  id_bad_branch_addr};
      nxt.csr = id_csr_op;
      nxt.valid = 1'b1;
    end
    model = nxt;
    scoreboard.push_back(nxt);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst = 1'b1;
    id_pc = '0; id_instruction = 32'h0020_8133; id_porta = '0; id_portb = '0; id_imm = '0;
    id_waddr = '0; id_we = 1'b1; id_mem_flags = 1'b0; id_mem_ex_sel = 1'b0;
    id_jump_op = 1'b0; id_branch_op = 1'b0; id_break_op = 1'b0; id_syscall_op = 1'b0;
    id_csr_imm_op = 1'b0; id_bad_jump_addr = 1'b0; id_bad_branch_addr = 1'b0;
    id_csr_op = 3'b000; id_stall = 1'b0; id_flush = 1'b0; ex_stall = 1'b0; ex_flush = 1'b0;
    model = bubble_value();

    applyStimulus("reset0");
    applyStimulus("reset1");
    chk("reset_nop_literal", ex_instruction, 32'h0000_0013);

    rst = 1'b0;
    id_pc = 32'h0000_0100; id_porta = 32'd5; id_portb = 32'd7; id_waddr = 5'd3;
    id_imm = 32'hFFFF_FFF0; id_mem_flags = 1'b1; id_mem_ex_sel = 1'b1;
    applyStimulus("load");
    chk("load_pc_literal", ex_pc, 32'h0000_0100);

    ex_stall = 1'b1;
    id_pc = 32'h0000_0104; id_porta = 32'd9; id_mem_flags = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus($sformatf("hold%0d", i));
    chk("hold_pc_literal", ex_pc, 32'h0000_0100);
    ex_stall = 1'b0;
    applyStimulus("release");
    chk("release_pc_literal", ex_pc, 32'h0000_0104);

    id_stall = 1'b1; id_branch_op = 1'b1; id_csr_op = 3'b001; id_bad_branch_addr = 1'b1;
    applyStimulus("id_stall_bubble");
    id_stall = 1'b0;
    applyStimulus("branch_csr_load");

    ex_flush = 1'b1; ex_stall = 1'b1;
    applyStimulus("flush_over_stall");
    ex_flush = 1'b0; ex_stall = 1'b0;
    id_branch_op = 1'b0; id_csr_op = 3'b000; id_bad_branch_addr = 1'b0;
    id_jump_op = 1'b1; id_pc = 32'h0000_0200;
    applyStimulus("reload");
    ex_stall = 1'b1; id_flush = 1'b1;
    applyStimulus("stall_over_id_flush");
    id_flush = 1'b0; id_stall = 1'b1; id_pc = 32'h0000_0204; id_jump_op = 1'b0;
    applyStimulus("both_stalls_hold");
    ex_stall = 1'b0; id_stall = 1'b0;
    applyStimulus("stalled_decode_load");
    applyStimulus("stalled_decode_repeat");

    ex_stall = 1'b1; rst = 1'b1;
    applyStimulus("reset_mid_stall");
    rst = 1'b0; ex_stall = 1'b0; id_syscall_op = 1'b1; id_pc = 32'h0000_0300;
    applyStimulus("syscall_after_reset");

    for (int i = 0; i < 24; i++) begin
      id_pc = $urandom; id_instruction = $urandom; id_porta = $urandom;
      id_portb = $urandom; id_imm = $urandom; id_waddr = 5'($urandom);
      {id_we, id_mem_flags, id_mem_ex_sel, id_jump_op, id_branch_op, id_break_op,
       id_syscall_op, id_csr_imm_op, id_bad_jump_addr, id_bad_branch_addr} = 10'($urandom);
      id_csr_op = 3'($urandom);
      id_stall = ($urandom_range(0, 3) == 0);
      id_flush = ($urandom_range(0, 5) == 0);
      ex_stall = ($urandom_range(0, 3) == 0);
      ex_flush = ($urandom_range(0, 6) == 0);
      rst      = ($urandom_range(0, 15) == 0);
      applyStimulus($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
